// File: rtl/hazard_stall_unit_pkg.sv
// Shared types and constants for the hazard/stall control unit.
package hazard_stall_unit_pkg;

    localparam int unsigned TIMEOUT_DEFAULT = 16;
    localparam int unsigned CNT_W_DEFAULT   = 32;
    localparam int unsigned REG_ADDR_W      = 5;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hazard_state_t;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_write;
        logic ex_mem_write;
        logic mem_wb_write;
        logic if_id_flush;
        logic id_ex_flush;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_NORMAL = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam pipe_ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam pipe_ctrl_t CTRL_FLUSH  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    localparam pipe_ctrl_t CTRL_STALL  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    // A load in EX whose destination feeds a source actually read in ID.
    function automatic logic load_use_hazard(
        input logic                  memread,
        input logic [REG_ADDR_W-1:0] rd,
        input logic [REG_ADDR_W-1:0] rs1,
        input logic                  rs1_used,
        input logic [REG_ADDR_W-1:0] rs2,
        input logic                  rs2_used
    );
        return memread && (rd != '0) &&
               ((rs1_used && (rs1 == rd)) || (rs2_used && (rs2 == rd)));
    endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Pipeline hazard inputs, register-enable/flush controls and counters.
interface hazard_stall_unit_if
    import hazard_stall_unit_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
);
    logic [REG_ADDR_W-1:0] ID_RS1;
    logic [REG_ADDR_W-1:0] ID_RS2;
    logic                  ID_RS1_USED;
    logic                  ID_RS2_USED;
    logic [REG_ADDR_W-1:0] ID_EX_RD;
    logic                  ID_EX_MEMREAD;
    logic                  EX_BRANCH_TAKEN;
    logic                  MEM_REQ;
    logic                  MEM_READY;

    logic                  PC_WRITE;
    logic                  IF_ID_WRITE;
    logic                  ID_EX_WRITE;
    logic                  EX_MEM_WRITE;
    logic                  MEM_WB_WRITE;
    logic                  IF_ID_FLUSH;
    logic                  ID_EX_FLUSH;
    logic                  MEM_ERR;
    logic [CNT_W-1:0]      STALL_CNT;
    logic [CNT_W-1:0]      FLUSH_CNT;
    logic [CNT_W-1:0]      WAIT_CNT;

    modport master (
        output ID_RS1, ID_RS2, ID_RS1_USED, ID_RS2_USED, ID_EX_RD,
               ID_EX_MEMREAD, EX_BRANCH_TAKEN, MEM_REQ, MEM_READY,
        input  PC_WRITE, IF_ID_WRITE, ID_EX_WRITE, EX_MEM_WRITE, MEM_WB_WRITE,
               IF_ID_FLUSH, ID_EX_FLUSH, MEM_ERR, STALL_CNT, FLUSH_CNT, WAIT_CNT
    );

    modport slave (
        input  ID_RS1, ID_RS2, ID_RS1_USED, ID_RS2_USED, ID_EX_RD,
               ID_EX_MEMREAD, EX_BRANCH_TAKEN, MEM_REQ, MEM_READY,
        output PC_WRITE, IF_ID_WRITE, ID_EX_WRITE, EX_MEM_WRITE, MEM_WB_WRITE,
               IF_ID_FLUSH, ID_EX_FLUSH, MEM_ERR, STALL_CNT, FLUSH_CNT, WAIT_CNT
    );

endinterface

// File: rtl/hazard_stall_unit_sat_counter.sv
// Saturating event counter with synchronous active-high reset.
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             INC,
    output logic [CNT_W-1:0] COUNT
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (INC && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign COUNT = count_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard controller: load-use stall, branch flush, data-memory freeze
// with timeout, plus saturating performance counters.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W   = CNT_W_DEFAULT
) (
    input  logic                CLK,
    input  logic                RST,
    hazard_stall_unit_if.slave  bus
);

    localparam int unsigned WCNT_W = $clog2(TIMEOUT + 1);

    hazard_state_t       state_q;
    hazard_state_t       state_d;
    logic [WCNT_W-1:0]   wcnt_q;
    logic [WCNT_W-1:0]   wcnt_d;
    logic                mem_err_q;
    logic                mem_err_d;

    logic                hazard;
    logic                mem_stall;
    pipe_ctrl_t          ctrl;
    logic                stall_inc;
    logic                flush_inc;
    logic                wait_inc;

    assign hazard    = load_use_hazard(bus.ID_EX_MEMREAD, bus.ID_EX_RD,
                                       bus.ID_RS1, bus.ID_RS1_USED,
                                       bus.ID_RS2, bus.ID_RS2_USED);
    assign mem_stall = bus.MEM_REQ && !bus.MEM_READY;

    // State register, wait counter and error pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= RUN;
            wcnt_q    <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    // Next state; the wait counter stops at TIMEOUT, where the wait is abandoned.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        mem_err_d = 1'b0;
        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d = MEM_WAIT;
                    wcnt_d  = WCNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (bus.MEM_READY) begin
                    state_d = RUN;
                    wcnt_d  = '0;
                end else if (wcnt_q == WCNT_W'(TIMEOUT)) begin
                    state_d   = RUN;
                    wcnt_d    = '0;
                    mem_err_d = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            default: begin
                state_d = RUN;
                wcnt_d  = '0;
            end
        endcase
    end

    // Pipeline controls, priority: memory freeze, branch flush, load-use stall.
    always_comb begin
        ctrl      = CTRL_NORMAL;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        wait_inc  = 1'b0;
        if (!RST) begin
            case (state_q)
                RUN: begin
                    if (mem_stall) begin
                        ctrl     = CTRL_FREEZE;
                        wait_inc = 1'b1;
                    end else if (bus.EX_BRANCH_TAKEN) begin
                        ctrl      = CTRL_FLUSH;
                        flush_inc = 1'b1;
                    end else if (hazard) begin
                        ctrl      = CTRL_STALL;
                        stall_inc = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    ctrl     = CTRL_FREEZE;
                    wait_inc = 1'b1;
                end
                default: begin
                    ctrl = CTRL_NORMAL;
                end
            endcase
        end
    end

    assign bus.PC_WRITE     = ctrl.pc_write;
    assign bus.IF_ID_WRITE  = ctrl.if_id_write;
    assign bus.ID_EX_WRITE  = ctrl.id_ex_write;
    assign bus.EX_MEM_WRITE = ctrl.ex_mem_write;
    assign bus.MEM_WB_WRITE = ctrl.mem_wb_write;
    assign bus.IF_ID_FLUSH  = ctrl.if_id_flush;
    assign bus.ID_EX_FLUSH  = ctrl.id_ex_flush;
    assign bus.MEM_ERR      = mem_err_q;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .INC   (stall_inc),
        .COUNT (bus.STALL_CNT)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .INC   (flush_inc),
        .COUNT (bus.FLUSH_CNT)
    );

    sat_counter #(.CNT_W(CNT_W)) u_wait_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .INC   (wait_inc),
        .COUNT (bus.WAIT_CNT)
    );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed and random bench for hazard_stall_unit against a cycle-level reference model.
module tb_hazard_stall_unit;

    localparam int unsigned TMO  = 4;
    localparam int unsigned CW   = 8;
    localparam int          MAXC = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;

    hazard_stall_unit_if #(.CNT_W(CW)) bus ();

    hazard_stall_unit #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: registered values visible during the current cycle.
    bit m_wait;
    int m_wcnt;
    int m_stall;
    int m_flush;
    int m_waitc;
    bit m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= MAXC) ? MAXC : v + 1;
    endfunction

    task automatic model_reset();
        m_wait = 0; m_wcnt = 0; m_stall = 0; m_flush = 0; m_waitc = 0; m_err = 0;
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance the model.
    task automatic step(input bit r, input int rs1, input int rs2, input bit u1, input bit u2,
                        input int rd, input bit mr, input bit br, input bit req, input bit rdy);
        logic [6:0] exp_ctrl;
        bit hz;
        @(negedge clk);
        rst                 = r;
        bus.ID_RS1          = 5'(rs1);
        bus.ID_RS2          = 5'(rs2);
        bus.ID_RS1_USED     = u1;
        bus.ID_RS2_USED     = u2;
        bus.ID_EX_RD        = 5'(rd);
        bus.ID_EX_MEMREAD   = mr;
        bus.EX_BRANCH_TAKEN = br;
        bus.MEM_REQ         = req;
        bus.MEM_READY       = rdy;
        #1;
        check("stall_cnt", 32'(bus.STALL_CNT), 32'(m_stall));
        check("flush_cnt", 32'(bus.FLUSH_CNT), 32'(m_flush));
        check("wait_cnt",  32'(bus.WAIT_CNT),  32'(m_waitc));
        check("mem_err",   32'(bus.MEM_ERR),   32'(m_err));
        hz = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        // exp_ctrl = {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}
        if (r) begin
            exp_ctrl = 7'b1111100;
            model_reset();
        end else if (m_wait) begin
            exp_ctrl = 7'b0000000;
            m_waitc  = sat_inc(m_waitc);
            m_err    = 0;
            if (rdy) begin
                m_wait = 0; m_wcnt = 0;
            end else if (m_wcnt == int'(TMO)) begin
                m_wait = 0; m_wcnt = 0; m_err = 1;
            end else begin
                m_wcnt++;
            end
        end else if (req && !rdy) begin
            exp_ctrl = 7'b0000000;
            m_waitc  = sat_inc(m_waitc);
            m_wait   = 1; m_wcnt = 1; m_err = 0;
        end else if (br) begin
            exp_ctrl = 7'b1111111;
            m_flush  = sat_inc(m_flush);
            m_err    = 0;
        end else if (hz) begin
            exp_ctrl = 7'b0011101;
            m_stall  = sat_inc(m_stall);
            m_err    = 0;
        end else begin
            exp_ctrl = 7'b1111100;
            m_err    = 0;
        end
        check("ctrl", 32'({bus.PC_WRITE, bus.IF_ID_WRITE, bus.ID_EX_WRITE, bus.EX_MEM_WRITE,
                           bus.MEM_WB_WRITE, bus.IF_ID_FLUSH, bus.ID_EX_FLUSH}), 32'(exp_ctrl));
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_rst();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.ID_RS1 = '0; bus.ID_RS2 = '0; bus.ID_RS1_USED = 1'b0; bus.ID_RS2_USED = 1'b0;
        bus.ID_EX_RD = '0; bus.ID_EX_MEMREAD = 1'b0; bus.EX_BRANCH_TAKEN = 1'b0;
        bus.MEM_REQ = 1'b0; bus.MEM_READY = 1'b0;
        @(posedge clk);
        model_reset();
        do_rst();
        idle();

        // Single load-use stall
        step(0, 5, 0, 1, 0, 5, 1, 0, 0, 0);
        idle();
        check("lu_stall_cnt", 32'(bus.STALL_CNT), 32'd1);

        // No stall for rd=0 or an unused matching source
        do_rst();
        step(0, 0, 0, 1, 1, 0, 1, 0, 0, 0);
        step(0, 7, 0, 0, 0, 7, 1, 0, 0, 0);
        idle();
        check("no_stall_cnt", 32'(bus.STALL_CNT), 32'd0);

        // Branch overrides load-use
        do_rst();
        step(0, 5, 0, 1, 0, 5, 1, 1, 0, 0);
        idle();
        check("br_flush_cnt", 32'(bus.FLUSH_CNT), 32'd1);
        check("br_stall_cnt", 32'(bus.STALL_CNT), 32'd0);

        // Memory wait of four frozen cycles
        do_rst();
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle();
        check("mw_wait_cnt", 32'(bus.WAIT_CNT), 32'd4);
        check("mw_no_err", 32'(bus.MEM_ERR), 32'd0);

        // Timeout after TMO+1 frozen cycles, then reset during a second wait
        do_rst();
        repeat (5) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle();
        check("tmo_err", 32'(bus.MEM_ERR), 32'd1);
        check("tmo_wait_cnt", 32'(bus.WAIT_CNT), 32'd5);
        idle();
        check("tmo_err_pulse", 32'(bus.MEM_ERR), 32'd0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle();
        check("rst_wait_cnt", 32'(bus.WAIT_CNT), 32'd0);
        check("rst_no_err", 32'(bus.MEM_ERR), 32'd0);
        idle();

        // Counter saturation
        do_rst();
        repeat (300) step(0, 5, 0, 1, 0, 5, 1, 0, 0, 0);
        idle();
        check("sat_stall_cnt", 32'(bus.STALL_CNT), 32'(MAXC));

        // Random traffic
        do_rst();
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 49) == 0),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 Parameter: TIMEOUT, default 16, maximum consecutive data-memory wait cycles before an error is flagged.
REQ-002 Parameter: CNT_W, default 32, width of each performance counter.
REQ-003 Port: CLK  in  1  single clock; every flop is updated on its rising edge.
REQ-004 Port: RST  in  1  reset; synchronous and active-high.
REQ-005 Port: ID_RS1, ID_RS2  in  5 each  source register addresses of the instruction in ID.
REQ-006 Port: ID_RS1_USED, ID_RS2_USED  in  1 each  the ID instruction reads RS1 / RS2.
REQ-007 Port: ID_EX_RD  in  5  destination register of the instruction in EX.
REQ-008 Port: ID_EX_MEMREAD  in  1  the instruction in EX is a load.
REQ-009 Port: EX_BRANCH_TAKEN  in  1  a branch or jump resolved in EX redirects the PC.
REQ-010 Port: MEM_REQ  in  1  data-memory access active in MEM; MEM_READY  in  1  memory completes the access this cycle.
REQ-011 Port: PC_WRITE, IF_ID_WRITE, ID_EX_WRITE, EX_MEM_WRITE, MEM_WB_WRITE  out  1 each  pipeline-register enables.
REQ-012 Port: IF_ID_FLUSH, ID_EX_FLUSH  out  1 each  load a NOP (bubble) into that register.
REQ-013 Port: MEM_ERR  out  1  one-cycle pulse on memory timeout.
REQ-014 Port: STALL_CNT, FLUSH_CNT, WAIT_CNT  out  CNT_W each  counts of load-use stall cycles, flush events and memory-wait cycles.

Function
REQ-015 FSM states: RUN, MEM_WAIT. The FSM is registered. All enable and flush outputs are combinational from the state and the current inputs.
REQ-016 Load-use hazard: ID_EX_MEMREAD=1, ID_EX_RD!=0, and (RS1_USED and RS1==RD, or RS2_USED and RS2==RD).
REQ-017 Load-use hazard in RUN, with no other condition: PC_WRITE=0, IF_ID_WRITE=0, ID_EX_FLUSH=1, and the remaining enables=1. This inserts exactly one bubble.
REQ-018 EX_BRANCH_TAKEN=1 in RUN: IF_ID_FLUSH=1, ID_EX_FLUSH=1, all enables=1. The branch overrides a simultaneous load-use hazard, so no stall and no STALL_CNT increment occur.
REQ-019 MEM_REQ=1 and MEM_READY=0 in RUN: all enables=0 and no flushes in the same cycle; the next state is MEM_WAIT and the wait counter loads 1.
REQ-020 In MEM_WAIT, all enables=0 and all flushes=0 regardless of the hazard and branch inputs. Those inputs are re-evaluated after the return to RUN.
REQ-021 MEM_WAIT to RUN when MEM_READY=1. The freeze is released in the following cycle, and the wait counter clears.
REQ-022 MEM_WAIT timeout: when the wait counter equals TIMEOUT and MEM_READY=0, MEM_ERR pulses for 1 cycle, the FSM returns to RUN, and the wait counter clears.
REQ-023 The internal wait counter is ceil(log2(TIMEOUT+1)) bits wide and never wraps.
REQ-024 Priority in RUN, highest first: memory wait, branch flush, load-use stall, normal flow (all enables=1, flushes=0).
REQ-025 MEM_REQ=1 with MEM_READY=1 in RUN causes no freeze.
REQ-026 Counter increments: STALL_CNT +1 per cycle where REQ-017 applies; FLUSH_CNT +1 per cycle where REQ-018 applies; WAIT_CNT +1 per cycle spent frozen (REQ-019 and REQ-020).
REQ-027 All counters saturate at 2^CNT_W-1.

Reset
REQ-028 RST=1 at a clock edge forces the following state: FSM=RUN, wait counter=0, STALL_CNT=FLUSH_CNT=WAIT_CNT=0, MEM_ERR=0.
REQ-029 During a cycle with RST=1, all enables=1, flushes=0 and no counter increments.
REQ-030 A reset asserted mid-MEM_WAIT abandons the wait with no MEM_ERR.

Structure
REQ-031 A shared package holds the hazard_state_t enum (RUN, MEM_WAIT) and the default TIMEOUT constant.
REQ-032 One sub-module, sat_counter (parameter CNT_W; ports CLK, RST, INC, COUNT), is instantiated three times.
REQ-033 No other sub-modules; no latches; next-state logic is in one always_comb block and flops are in always_ff blocks.

Verification
REQ-034 Load-use: ID_EX_MEMREAD=1, ID_EX_RD=5, ID_RS1=5, ID_RS1_USED=1 for 1 cycle -> PC_WRITE=0, IF_ID_WRITE=0, ID_EX_FLUSH=1 that cycle; STALL_CNT=1.
REQ-035 RD=0 or RS1_USED=0 with a matching address -> no stall; STALL_CNT stays 0.
REQ-036 EX_BRANCH_TAKEN=1 together with the load-use condition -> IF_ID_FLUSH=ID_EX_FLUSH=1, PC_WRITE=1; FLUSH_CNT=1, STALL_CNT=0.
REQ-037 MEM_REQ=1, MEM_READY=0 for 3 cycles, then READY=1 -> all enables 0 for 4 cycles, release on the next cycle; WAIT_CNT=4, MEM_ERR never set.
REQ-038 TIMEOUT=4 with READY held 0 -> MEM_ERR pulse on the 5th frozen cycle, FSM=RUN afterwards; RST asserted in cycle 2 of a second wait -> FSM=RUN, counters 0, no MEM_ERR.
